// File: rtl/shift_pkg.sv
// Shared types and defaults for the shift-register feeder.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 2;

  // Bits needed to index n items; never less than one.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_4_feeder_if.sv
// Upstream word handshake plus the shift-register control bus.
interface shift_reg_4_feeder_if
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             stall;
  logic             sr_load;
  logic             sr_ena;
  logic [WIDTH-1:0] sr_data;
  logic             busy;
  logic             word_done;

  modport master (
    output in_data, in_valid, stall,
    input  in_ready, sr_load, sr_ena, sr_data, busy, word_done
  );

  modport slave (
    input  in_data, in_valid, stall,
    output in_ready, sr_load, sr_ena, sr_data, busy, word_done
  );

endinterface

// File: rtl/shift_reg_4_feeder_sync_fifo.sv
// Small synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [WIDTH-1:0]   i_data,
  output logic [WIDTH-1:0]   o_head,
  output logic [cnt_bits(DEPTH):0] o_count,
  output logic               o_full,
  output logic               o_empty
);

  localparam int AW = cnt_bits(DEPTH);
  localparam logic [AW:0] C_DEPTH = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == C_DEPTH);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/shift_reg_4_feeder.sv
// Feeds buffered words to a load/shift register: one load strobe, then WIDTH shift enables.
module shift_reg_4_feeder
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               areset,
  shift_reg_4_feeder_if.slave bus
);

  localparam int AW = cnt_bits(DEPTH);
  localparam int CW = cnt_bits(WIDTH);
  localparam logic [AW:0]   C_DEPTH = DEPTH[AW:0];
  localparam logic [CW-1:0] C_LAST  = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sr_data;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  logic [AW:0]      w_count;
  logic             w_full;
  logic             w_empty;

  logic             w_sr_load;
  logic             w_sr_ena;
  logic             w_word_done;
  logic             w_busy;

  assign w_push = bus.in_valid && !w_full;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .areset  (areset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.in_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // A pop happens only on the edge that enters LOAD, so sr_data is captured there.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_next = LOAD;
          w_pop  = 1'b1;
        end
      end
      LOAD: w_next = SHIFT;
      SHIFT: begin
        if (w_word_done) begin
          if (!w_empty) begin
            w_next = LOAD;
            w_pop  = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_sr_load   = (r_state == LOAD);
    w_sr_ena    = (r_state == SHIFT) && !bus.stall;
    w_word_done = w_sr_ena && (r_cnt == C_LAST);
    w_busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_cnt     <= '0;
      r_sr_data <= '0;
    end else begin
      if (r_state == LOAD) r_cnt <= '0;
      else if (w_sr_ena)   r_cnt <= r_cnt + 1'b1;
      if (w_pop) r_sr_data <= w_head;
    end
  end

  assign bus.in_ready  = (w_count < C_DEPTH);
  assign bus.sr_load   = w_sr_load;
  assign bus.sr_ena    = w_sr_ena;
  assign bus.sr_data   = r_sr_data;
  assign bus.busy      = w_busy;
  assign bus.word_done = w_word_done;

endmodule
